mtr_drv: RTL and testbench
==========================

Name: mtr_drv

Overview:
- Consumes the signed 11-bit wheel speed commands produced by the PID steering block and drives the left and right H-bridges.
- Each side gets a forward and a reverse PWM output.
- Each side has a direction-change dead-time interlock.
- Duty and direction update only at PWM period boundaries, so the outputs are glitch-free.

Parameters:
- PWM_W, 11, PWM counter width; period = 2^PWM_W = 2048 cycles.
- DEADTIME, 32, cycles with both bridge legs low after a direction reversal; legal range 1..2^PWM_W-2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  drive enable (robot moving); low forces both bridges off
- lft_spd  input  11  signed left speed command, two's complement
- rght_spd  input  11  signed right speed command, two's complement
- lft_fwd  output  1  left forward PWM
- lft_rev  output  1  left reverse PWM
- rght_fwd  output  1  right forward PWM
- rght_rev  output  1  right reverse PWM
- period_strt  output  1  one-cycle pulse, high while cnt==0

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high (polarity and synchronicity fixed). Reset sets: cnt=0, both channels IDLE, duty_q=0, dead_cnt=0, all PWM outputs 0, period_strt=0.
- cnt: PWM_W-bit free-running up counter; wraps 2047->0. The boundary is the cycle with cnt==2047.
- period_strt is registered, high exactly when cnt==0; it is first asserted 2048 cycles after reset release.
- Magnitude: mag = |spd|, 10 bits. Negative input is negated; -1024 saturates to 1023.
- Duty: duty = {mag,1'b0}, 11 bits, range 0..2046. dir_req = spd[10] (1 = reverse).
- Duty load: at each boundary, duty_q <= duty, regardless of state.
- Per-channel FSM states are IDLE, FWD, REV, DEAD. Transitions occur at the boundary unless noted.
  - IDLE: if en && spd!=0, go to FWD (dir_req=0) or REV (dir_req=1). No dead time is needed because both legs are already low.
  - FWD: if dir_req=1 && spd!=0, go to DEAD with tgt=REV and dead_cnt=DEADTIME. Otherwise stay; spd==0 gives duty 0, so outputs stay low.
  - REV: symmetric to FWD (dir_req=0 && spd!=0 goes to DEAD with tgt=FWD).
  - DEAD: dead_cnt decrements every cycle. DEAD occupies exactly cnt=0..DEADTIME-1, and the target state is entered at cnt==DEADTIME. No boundary can occur in DEAD, given the DEADTIME range.
- en low in any state: go to IDLE on the next clock edge, not waiting for a boundary. en has priority over every other transition.
- Outputs are registered, one cycle latency:
  - fwd(t+1) = (state(t)==FWD) && (cnt(t) < duty_q(t)).
  - rev(t+1) = (state(t)==REV) && (cnt(t) < duty_q(t)).
- Invariant: fwd and rev of one side are never both 1.
- Invariant: at least DEADTIME cycles of both legs low separate any fwd pulse from any rev pulse on the same side.
- Left and right channels are fully independent and share only cnt.
- Reset asserted mid-period or mid-DEAD: all outputs are 0 on the next cycle, and the full reset state applies.

Decomposition:
- Package mtr_drv_pkg holds:
  - typedef enum logic [1:0] chan_state_t {IDLE, FWD, REV, DEAD};
  - localparams PWM_PERIOD and DUTY_MAX=2046.
- Sub-module mtr_chan is instantiated twice. Per side it holds: magnitude/saturation, duty_q, FSM, dead_cnt, and the output flops. Its inputs are cnt, boundary and en.
- Top mtr_drv holds cnt, the boundary decode and period_strt.

Test Plan:
- Reset release, en=1, lft_spd=256 held: first period no pulses; from the following cnt==0, lft_fwd high for 512 cycles (delayed 1 cycle), low for 1536; lft_rev stays 0.
- rght_spd=-1024 (11'h400): rght_rev high 2046 of every 2048 cycles; rght_fwd 0. Checks saturation to 1023.
- lft_spd 300 for one period, then -300 before the boundary, DEADTIME=32:
  - next period lft_fwd=0 throughout;
  - lft_rev low for cnt 0..31, then high for 568 cycles (cnt 32..599, +1 latency);
  - from the following period, 600 high cycles per period.
- en dropped at cnt=700 while lft_fwd is high (spd=500): lft_fwd 0 within 2 cycles; state IDLE. en reasserted: pulses resume only after the next boundary.
- spd=0 while in FWD: outputs low for the whole period; state stays FWD. Then spd=+100 gives 200-cycle pulses with no dead time.
- rst asserted during DEAD and mid-pulse: all outputs 0 the next cycle. After release: period_strt first high 2048 cycles later; no pulse for the first period.

Source files
------------

// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the dual H-bridge PWM driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mtr_drv_pkg;

    localparam int PWM_W_DEF  = 11;
    localparam int PWM_PERIOD = 2 ** PWM_W_DEF;
    localparam int DUTY_MAX   = 2046;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2,
        DEAD = 2'd3
    } chan_state_t;

endpackage

// File: rtl/mtr_chan.sv
// One H-bridge side: speed magnitude, duty latch, direction FSM with dead time, PWM flops.
// Latency: duty/direction take effect at the next period boundary; PWM outputs lag cnt by one cycle.
// Backpressure: none; en low forces IDLE on the next edge.
module mtr_chan
    import mtr_drv_pkg::*;
#(
    parameter int PWM_W    = 11,
    parameter int DEADTIME = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             boundary,
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W-1:0] spd,
    output logic             fwd,
    output logic             rev
);

    localparam logic [PWM_W-1:0] DEAD_INIT = PWM_W'(DEADTIME);

    logic [PWM_W-2:0] mag;
    logic [PWM_W-1:0] neg;
    logic [PWM_W-1:0] duty;
    logic [PWM_W-1:0] duty_q;
    logic [PWM_W-1:0] dead_cnt;
    logic             dir_req;
    logic             spd_nz;
    logic             fwd_d;
    logic             rev_d;
    chan_state_t      state;
    chan_state_t      state_nxt;
    chan_state_t      tgt;

    assign dir_req = spd[PWM_W-1];
    assign spd_nz  = (spd != '0);
    assign neg     = ~spd + PWM_W'(1);
    assign duty    = {mag, 1'b0};

    // Magnitude of the command; the most negative code cannot be negated and saturates.
    always_comb begin
        mag = spd[PWM_W-2:0];
        if (dir_req) begin
            if (neg[PWM_W-1]) mag = '1;
            else              mag = neg[PWM_W-2:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: en has absolute priority, reversals detour through DEAD.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (boundary && spd_nz) state_nxt = dir_req ? REV : FWD;
                FWD:  if (boundary && spd_nz && dir_req)  state_nxt = DEAD;
                REV:  if (boundary && spd_nz && !dir_req) state_nxt = DEAD;
                DEAD: if (dead_cnt == PWM_W'(1)) state_nxt = tgt;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // PWM compare: a leg is driven only in its own direction state.
    always_comb begin
        fwd_d = (state == FWD) && (cnt < duty_q);
        rev_d = (state == REV) && (cnt < duty_q);
    end

    // Duty latch, dead-time counter and reversal target.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q   <= '0;
            dead_cnt <= '0;
            tgt      <= IDLE;
        end else begin
            if (boundary) duty_q <= duty;
            if (state_nxt == DEAD && state != DEAD) begin
                dead_cnt <= DEAD_INIT;
                tgt      <= dir_req ? REV : FWD;
            end else if (state == DEAD) begin
                dead_cnt <= dead_cnt - PWM_W'(1);
            end else begin
                dead_cnt <= '0;
            end
        end
    end

    // Registered bridge outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd <= 1'b0;
            rev <= 1'b0;
        end else begin
            fwd <= fwd_d;
            rev <= rev_d;
        end
    end

endmodule

// File: rtl/mtr_drv.sv
// Dual-side motor driver: shared PWM counter and boundary decode feeding two channel instances.
// Latency: outputs registered, one cycle behind cnt; commands apply at the next period boundary.
// Backpressure: none; commands are sampled continuously.
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter int PWM_W    = 11,
    parameter int DEADTIME = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PWM_W-1:0] lft_spd,
    input  logic [PWM_W-1:0] rght_spd,
    output logic             lft_fwd,
    output logic             lft_rev,
    output logic             rght_fwd,
    output logic             rght_rev,
    output logic             period_strt
);

    logic [PWM_W-1:0] cnt;
    logic             boundary;

    assign boundary = (cnt == '1);

    // Free-running period counter and period-start flag (high while cnt==0).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            period_strt <= 1'b0;
        end else begin
            cnt         <= cnt + PWM_W'(1);
            period_strt <= boundary;
        end
    end

    mtr_chan #(
        .PWM_W    (PWM_W),
        .DEADTIME (DEADTIME)
    ) u_lft (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .boundary (boundary),
        .cnt      (cnt),
        .spd      (lft_spd),
        .fwd      (lft_fwd),
        .rev      (lft_rev)
    );

    mtr_chan #(
        .PWM_W    (PWM_W),
        .DEADTIME (DEADTIME)
    ) u_rght (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .boundary (boundary),
        .cnt      (cnt),
        .spd      (rght_spd),
        .fwd      (rght_fwd),
        .rev      (rght_rev)
    );

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: pulse widths, dead time, en drop, zero speed, reset recovery.
// Latency: n/a.
// Backpressure: n/a.
module tb_mtr_drv;
    import mtr_drv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        lft_fwd;
    logic        lft_rev;
    logic        rght_fwd;
    logic        rght_rev;
    logic        period_strt;

    int checks = 0;
    int errors = 0;
    int n_lf, n_lr, n_rf, n_rr, n_ps;
    int f_lf, f_lr, l_lf, l_lr;
    int ovl = 0;

    mtr_drv #(.PWM_W(11), .DEADTIME(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .lft_spd     (lft_spd),
        .rght_spd    (rght_spd),
        .lft_fwd     (lft_fwd),
        .lft_rev     (lft_rev),
        .rght_fwd    (rght_fwd),
        .rght_rev    (rght_rev),
        .period_strt (period_strt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample n consecutive cycles at negedge, starting with the current one.
    task automatic measure(input int n);
        n_lf = 0; n_lr = 0; n_rf = 0; n_rr = 0; n_ps = 0;
        f_lf = -1; f_lr = -1; l_lf = -1; l_lr = -1;
        for (int i = 0; i < n; i++) begin
            if (lft_fwd) begin n_lf++; if (f_lf < 0) f_lf = i; l_lf = i; end
            if (lft_rev) begin n_lr++; if (f_lr < 0) f_lr = i; l_lr = i; end
            if (rght_fwd) n_rf++;
            if (rght_rev) n_rr++;
            if (period_strt) n_ps++;
            if ((lft_fwd && lft_rev) || (rght_fwd && rght_rev)) ovl++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; lft_spd = '0; rght_spd = '0;
        repeat (4) @(negedge clk);
        check("rst_lft_fwd", int'(lft_fwd), 0);
        check("rst_lft_rev", int'(lft_rev), 0);
        check("rst_rght_fwd", int'(rght_fwd), 0);
        check("rst_rght_rev", int'(rght_rev), 0);
        check("rst_pstrt", int'(period_strt), 0);
        check("rst_cnt", int'(u_dut.cnt), 0);
        check("rst_state", int'(u_dut.u_lft.state), int'(IDLE));

        // Release: left +256, right -1024 (saturates to 1023 -> duty 2046).
        lft_spd = 11'd256; rght_spd = 11'h400; en = 1'b1; rst = 1'b0;
        measure(PWM_PERIOD);
        check("p1_lft_fwd", n_lf, 0);
        check("p1_rght_rev", n_rr, 0);
        check("p1_pstrt", n_ps, 0);
        check("p1_pstrt_first", int'(period_strt), 1);
        check("p1_cnt_wrap", int'(u_dut.cnt), 0);

        measure(PWM_PERIOD);
        check("p2_lft_fwd_n", n_lf, 512);
        check("p2_lft_fwd_first", f_lf, 1);
        check("p2_lft_fwd_last", l_lf, 512);
        check("p2_lft_rev_n", n_lr, 0);
        check("p2_rght_rev_n", n_rr, DUTY_MAX);
        check("p2_rght_fwd_n", n_rf, 0);
        check("p2_pstrt_n", n_ps, 1);

        lft_spd = 11'd300;
        measure(PWM_PERIOD);
        check("p3_lft_fwd_n", n_lf, 512);

        lft_spd = 11'h6D4;  // -300
        measure(PWM_PERIOD);
        check("p4_lft_fwd_n", n_lf, 600);

        measure(PWM_PERIOD);
        check("p5_lft_fwd_n", n_lf, 0);
        check("p5_lft_rev_n", n_lr, 568);
        check("p5_lft_rev_first", f_lr, 33);
        check("p5_lft_rev_last", l_lr, 600);

        lft_spd = 11'd500;
        measure(PWM_PERIOD);
        check("p6_lft_rev_n", n_lr, 600);
        check("p6_lft_rev_first", f_lr, 1);

        measure(PWM_PERIOD);
        check("p7_lft_rev_n", n_lr, 0);
        check("p7_lft_fwd_n", n_lf, 968);
        check("p7_lft_fwd_first", f_lf, 33);

        measure(PWM_PERIOD);
        check("p8_lft_fwd_n", n_lf, 1000);

        // Drop en at cnt 700 while the forward leg is high.
        measure(700);
        check("en_pre_lft_fwd", int'(lft_fwd), 1);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("en_off_lft_fwd", int'(lft_fwd), 0);
        check("en_off_rght_rev", int'(rght_rev), 0);
        check("en_off_lft_state", int'(u_dut.u_lft.state), int'(IDLE));
        check("en_off_rght_state", int'(u_dut.u_rght.state), int'(IDLE));
        en = 1'b1;
        measure(PWM_PERIOD - 702);
        check("en_rest_lft_fwd", n_lf, 0);
        check("en_rest_rght_rev", n_rr, 0);
        check("en_rest_cnt", int'(u_dut.cnt), 0);

        lft_spd = 11'd0;
        measure(PWM_PERIOD);
        check("p10_lft_fwd_n", n_lf, 1000);
        check("p10_rght_rev_n", n_rr, DUTY_MAX);

        lft_spd = 11'd100;
        measure(PWM_PERIOD);
        check("p11_lft_fwd_n", n_lf, 0);
        check("p11_lft_rev_n", n_lr, 0);
        check("p11_lft_state", int'(u_dut.u_lft.state), int'(FWD));

        lft_spd = 11'h79C;  // -100
        measure(PWM_PERIOD);
        check("p12_lft_fwd_n", n_lf, 200);
        check("p12_lft_fwd_first", f_lf, 1);

        // Into DEAD on the left while the right leg is mid-pulse, then reset.
        measure(10);
        check("p13_lft_state", int'(u_dut.u_lft.state), int'(DEAD));
        check("p13_rght_rev", int'(rght_rev), 1);
        check("p13_lft_out", int'(lft_fwd | lft_rev), 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_outs", int'({lft_fwd, lft_rev, rght_fwd, rght_rev}), 0);
        check("rst2_pstrt", int'(period_strt), 0);
        check("rst2_cnt", int'(u_dut.cnt), 0);
        check("rst2_state", int'(u_dut.u_lft.state), int'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        measure(PWM_PERIOD);
        check("r1_pulses", n_lf + n_lr + n_rf + n_rr, 0);
        check("r1_pstrt_n", n_ps, 0);
        check("r1_pstrt_first", int'(period_strt), 1);

        measure(PWM_PERIOD);
        check("r2_lft_rev_n", n_lr, 200);
        check("r2_lft_rev_first", f_lr, 1);
        check("r2_lft_fwd_n", n_lf, 0);
        check("r2_rght_rev_n", n_rr, DUTY_MAX);
        check("overlap", ovl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
